// File: rtl/fabric_port_arbiter.sv
// Two-master (instruction/data) OCP port arbiter with round-robin priority and one transaction in flight.
// Optional RESP-state timeout abort is built only when FABRIC_ARB_TIMEOUT_EN is defined.
module fabric_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_WIDTH      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] i_I_MCmd,
    input  logic [2:0] i_D_MCmd,
    input  logic       i_P_SCmdAccept,
    input  logic [1:0] i_P_SResp,
    output logic       o_select,
    output logic       o_busy,
    output logic       o_timeout
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] CMD_IDLE  = 3'b000;
    localparam logic [1:0] RESP_NULL = 2'b00;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       r_sel;
    logic       last_i;
    logic       req_i;
    logic       req_d;
    logic       any_req;
    logic       win_i;
    logic       resp_vld;
    logic       tmo_hit;

    assign req_i    = (i_I_MCmd != CMD_IDLE);
    assign req_d    = (i_D_MCmd != CMD_IDLE);
    assign any_req  = req_i | req_d;
    assign resp_vld = (i_P_SResp != RESP_NULL);

    // On a tie the master that was not granted last wins; a sole requester always wins.
    assign win_i = (req_i && req_d) ? ~last_i : req_i;

    assign o_select = (state == ST_IDLE && any_req) ? win_i : r_sel;
    assign o_busy   = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    if (i_P_SCmdAccept && resp_vld) state_nxt = ST_IDLE;
                    else if (i_P_SCmdAccept)        state_nxt = ST_RESP;
                    else                            state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                if (i_P_SCmdAccept && resp_vld) state_nxt = ST_IDLE;
                else if (i_P_SCmdAccept)        state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (resp_vld || tmo_hit) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            r_sel  <= 1'b0;
            last_i <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && any_req) begin
                r_sel  <= win_i;
                last_i <= win_i;
            end
        end
    end

`ifdef FABRIC_ARB_TIMEOUT_EN
    // Counter holds (RESP cycles so far - 1); the abort fires on the edge where it would reach TIMEOUT_CYCLES.
    localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TMO_WIDTH-1:0] tmo_cnt;
    logic                 tmo_q;

    assign tmo_hit   = (state == ST_RESP) && !resp_vld && (tmo_cnt == TMO_LAST);
    assign o_timeout = tmo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            tmo_q   <= 1'b0;
        end else begin
            tmo_q <= tmo_hit;
            if (state != ST_RESP && state_nxt == ST_RESP)
                tmo_cnt <= '0;
            else if (state == ST_RESP && !resp_vld)
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    logic [31:0] unused_cfg;

    assign unused_cfg = 32'(TIMEOUT_CYCLES) ^ 32'(TMO_WIDTH);
    assign tmo_hit    = 1'b0;
    assign o_timeout  = 1'b0;
`endif

endmodule
